multicycle_seq: RTL and testbench

- Multi-cycle sequencer for the RV32I-subset core. Steps each instruction through fetch, decode, execute, memory and writeback, and handshakes with the instruction and data memories.
- Generates the datapath controls: register write, immediate select, ALU opcode class and memory-to-register select.
- Sits between the instruction register/PC logic, the register file/ALU datapath, and the memory ports.
- Adds an illegal-opcode trap and a memory-response watchdog that halts the core.

---
 rtl/multicycle_seq_if.sv | 30 +++
 rtl/multicycle_seq.sv | 126 ++++++++++++
 tb/tb_multicycle_seq.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/multicycle_seq_if.sv
// Control bundle between the multi-cycle sequencer, the IR/PC logic,
// the datapath and the instruction/data memory ports.
interface multicycle_seq_if;
   logic [6:0] opcode;
   logic       imem_req;
   logic       imem_ack;
   logic       dmem_req;
   logic       dmem_we;
   logic       dmem_ack;
   logic       ir_write;
   logic       pc_write;
   logic       reg_write;
   logic       imm_data;
   logic [1:0] opcode_alu;
   logic       mem_to_reg;
   logic       retire;
   logic       err;

   modport master (
      input  opcode, imem_ack, dmem_ack,
      output imem_req, dmem_req, dmem_we, ir_write, pc_write, reg_write,
             imm_data, opcode_alu, mem_to_reg, retire, err
   );

   modport slave (
      output opcode, imem_ack, dmem_ack,
      input  imem_req, dmem_req, dmem_we, ir_write, pc_write, reg_write,
             imm_data, opcode_alu, mem_to_reg, retire, err
   );
endinterface

// File: rtl/multicycle_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I-subset core,
// with illegal-opcode trap and memory-response watchdog that halt the core.
module multicycle_seq #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   multicycle_seq_if.master bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   localparam logic [4:0] OP_IMM   = 5'b00100;
   localparam logic [4:0] OP_REG   = 5'b01100;
   localparam logic [4:0] OP_LOAD  = 5'b00000;
   localparam logic [4:0] OP_STORE = 5'b01000;

   localparam bit          WD_EN  = (MEM_TIMEOUT > 0);
   localparam int          CW     = WD_EN ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam int          LAST_I = WD_EN ? MEM_TIMEOUT - 1 : 0;
   localparam logic [CW-1:0] LAST = CW'(LAST_I);

   state_t        state, state_nx;
   logic [4:0]    op_q;       // opcode[6:2]; the low bits are always 2'b11 once legal
   logic [CW-1:0] wd_cnt;
   logic          legal, is_mem_op, is_store, wd_hit, waiting;

   always_comb begin
      legal     = (bus.opcode[1:0] == 2'b11) &&
                  (bus.opcode[6:2] inside {OP_IMM, OP_REG, OP_LOAD, OP_STORE});
      is_store  = (op_q == OP_STORE);
      is_mem_op = (op_q == OP_LOAD) || is_store;
      wd_hit    = WD_EN && (wd_cnt == LAST);
      waiting   = ((state == S_FETCH) && !bus.imem_ack) ||
                  ((state == S_MEM)   && !bus.dmem_ack);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         op_q   <= '0;
         wd_cnt <= '0;
      end else begin
         state <= state_nx;
         if (state == S_DECODE) op_q <= bus.opcode[6:2];
         // Count only while a request is outstanding; any other state leaves
         // the counter at zero so entry to FETCH/MEM always starts fresh.
         if (waiting) begin
            if (WD_EN) wd_cnt <= wd_cnt + CW'(1);
         end else begin
            wd_cnt <= '0;
         end
      end
   end

   always_comb begin
      state_nx       = state;
      bus.imem_req   = 1'b0;
      bus.dmem_req   = 1'b0;
      bus.dmem_we    = 1'b0;
      bus.ir_write   = 1'b0;
      bus.pc_write   = 1'b0;
      bus.reg_write  = 1'b0;
      bus.imm_data   = 1'b0;
      bus.opcode_alu = 2'b10;
      bus.mem_to_reg = 1'b0;
      bus.retire     = 1'b0;
      bus.err        = 1'b0;

      if (state inside {S_EXEC, S_MEM, S_WB}) begin
         case (op_q)
            OP_IMM:   begin bus.imm_data = 1'b1; bus.opcode_alu = 2'b01; end
            OP_REG:   begin bus.imm_data = 1'b0; bus.opcode_alu = 2'b11; end
            OP_LOAD:  begin bus.imm_data = 1'b1; bus.opcode_alu = 2'b00; bus.mem_to_reg = 1'b1; end
            OP_STORE: begin bus.imm_data = 1'b1; bus.opcode_alu = 2'b00; end
            default:  ;
         endcase
      end

      case (state)
         S_IDLE:   state_nx = S_FETCH;
         S_FETCH: begin
            bus.imem_req = 1'b1;
            if (bus.imem_ack) begin
               bus.ir_write = 1'b1;
               state_nx     = S_DECODE;
            end else if (wd_hit) begin
               state_nx = S_HALT;
            end
         end
         S_DECODE: state_nx = legal ? S_EXEC : S_HALT;
         S_EXEC:   state_nx = is_mem_op ? S_MEM : S_WB;
         S_MEM: begin
            bus.dmem_req = 1'b1;
            bus.dmem_we  = is_store;
            if (bus.dmem_ack)  state_nx = S_WB;
            else if (wd_hit)   state_nx = S_HALT;
         end
         S_WB: begin
            bus.pc_write  = 1'b1;
            bus.retire    = 1'b1;
            bus.reg_write = !is_store;
            state_nx      = S_FETCH;
         end
         S_HALT:   bus.err = 1'b1;
         default:  state_nx = S_IDLE;
      endcase

      // Reset wins over everything, including same-cycle acks and timeouts.
      if (!rst_n) begin
         state_nx       = S_IDLE;
         bus.imem_req   = 1'b0;
         bus.dmem_req   = 1'b0;
         bus.dmem_we    = 1'b0;
         bus.ir_write   = 1'b0;
         bus.pc_write   = 1'b0;
         bus.reg_write  = 1'b0;
         bus.imm_data   = 1'b0;
         bus.opcode_alu = 2'b10;
         bus.mem_to_reg = 1'b0;
         bus.retire     = 1'b0;
         bus.err        = 1'b0;
      end
   end
endmodule

// File: tb/tb_multicycle_seq.sv
// Directed bench for multicycle_seq: per-cycle vector table plus hand-written
// sequences for illegal-opcode halt and data-memory timeout.
module tb_multicycle_seq;
   logic clk = 1'b0;
   logic rst_n;
   multicycle_seq_if bus ();

   multicycle_seq #(.MEM_TIMEOUT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [6:0]  op;
      logic        iack;
      logic        dack;
      logic [11:0] exp;
   } vec_t;

   // {imem_req,dmem_req,dmem_we,ir_write,pc_write,reg_write,imm_data}_{alu}_{mem_to_reg,retire,err}
   localparam logic [11:0] O_IDLE = 12'b0000000_10_000;
   localparam logic [11:0] O_FI   = 12'b1001000_10_000;
   localparam logic [11:0] O_FW   = 12'b1000000_10_000;
   localparam logic [11:0] O_HALT = 12'b0000000_10_001;

   localparam logic [6:0] OPI = 7'b0010011;
   localparam logic [6:0] OPR = 7'b0110011;
   localparam logic [6:0] LD  = 7'b0000011;
   localparam logic [6:0] ST  = 7'b0100011;
   localparam logic [6:0] BAD = 7'b1100011;

   vec_t tv[$];
   int total = 0;
   int bad   = 0;
   logic [11:0] obs;

   assign obs = {bus.imem_req, bus.dmem_req, bus.dmem_we, bus.ir_write, bus.pc_write,
                 bus.reg_write, bus.imm_data, bus.opcode_alu, bus.mem_to_reg,
                 bus.retire, bus.err};

   task automatic add(input logic r, input logic [6:0] op, input logic ia, input logic da,
                      input logic [11:0] e);
      vec_t v;
      v.rst = r; v.op = op; v.iack = ia; v.dack = da; v.exp = e;
      tv.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic [6:0] op, input logic ia, input logic da);
      @(negedge clk);
      rst_n = r; bus.opcode = op; bus.imem_ack = ia; bus.dmem_ack = da;
      #1;
   endtask

   initial begin
      int n;
      logic seen_bad;
      rst_n = 1'b0; bus.opcode = '0; bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;

      // reset, then IDLE with stray acks that must be ignored
      add(0, OPI, 0, 0, O_IDLE);
      add(1, OPI, 1, 1, O_IDLE);
      // OP-IMM, zero wait
      add(1, OPI, 1, 0, O_FI);
      add(1, OPI, 1, 0, O_IDLE);
      add(1, OPI, 1, 0, 12'b0000001_01_000);
      add(1, OPI, 1, 0, 12'b0000111_01_010);
      // OP
      add(1, OPR, 1, 0, O_FI);
      add(1, OPR, 1, 0, O_IDLE);
      add(1, OPR, 1, 0, 12'b0000000_11_000);
      add(1, OPR, 1, 0, 12'b0000110_11_010);
      // LOAD, ack on third MEM cycle
      add(1, LD, 1, 0, O_FI);
      add(1, LD, 1, 0, O_IDLE);
      add(1, LD, 1, 0, 12'b0000001_00_100);
      add(1, LD, 1, 0, 12'b0100001_00_100);
      add(1, LD, 1, 0, 12'b0100001_00_100);
      add(1, LD, 1, 1, 12'b0100001_00_100);
      add(1, LD, 1, 0, 12'b0000111_00_110);
      // STORE, immediate acks
      add(1, ST, 1, 0, O_FI);
      add(1, ST, 1, 0, O_IDLE);
      add(1, ST, 1, 0, 12'b0000001_00_000);
      add(1, ST, 1, 1, 12'b0110001_00_000);
      add(1, ST, 1, 0, 12'b0000101_00_010);
      // fetch ack in the final watchdog cycle wins
      add(1, LD, 0, 0, O_FW);
      add(1, LD, 0, 0, O_FW);
      add(1, LD, 0, 0, O_FW);
      add(1, LD, 1, 0, O_FI);
      add(1, LD, 0, 0, O_IDLE);
      add(1, LD, 0, 0, 12'b0000001_00_100);
      add(1, LD, 0, 0, 12'b0100001_00_100);
      // reset during MEM wait with a same-cycle ack
      add(0, LD, 0, 1, O_IDLE);
      add(1, LD, 0, 0, O_IDLE);
      // fetch never acked: four request cycles, then HALT
      add(1, LD, 0, 0, O_FW);
      add(1, LD, 0, 0, O_FW);
      add(1, LD, 0, 0, O_FW);
      add(1, LD, 0, 0, O_FW);
      add(1, LD, 1, 1, O_HALT);
      add(1, LD, 1, 1, O_HALT);

      foreach (tv[i]) begin
         step(tv[i].rst, tv[i].op, tv[i].iack, tv[i].dack);
         chk($sformatf("vec%0d", i), 32'(obs), 32'(tv[i].exp));
      end

      // illegal opcode: halt and hold with no further fetch or retire
      step(0, BAD, 1, 0);
      step(1, BAD, 1, 0);
      step(1, BAD, 1, 0);
      chk("illegal_fetch_irw", 32'(bus.ir_write), 32'd1);
      step(1, BAD, 1, 0);
      chk("illegal_decode_err", 32'(bus.err), 32'd0);
      step(1, BAD, 1, 0);
      chk("illegal_err_set", 32'(bus.err), 32'd1);
      seen_bad = 1'b0;
      for (int k = 0; k < 22; k++) begin
         step(1, BAD, 1, 1);
         if (bus.imem_req || bus.retire || bus.pc_write || !bus.err) seen_bad = 1'b1;
      end
      chk("illegal_halt_hold", 32'(seen_bad), 32'd0);

      // data-memory timeout on a STORE
      step(0, ST, 0, 0);
      step(1, ST, 1, 0);
      step(1, ST, 1, 0);
      step(1, ST, 0, 0);
      step(1, ST, 0, 0);
      n = 0;
      for (int k = 0; k < 50; k++) begin
         step(1, ST, 0, 0);
         if (!bus.dmem_req) break;
         if (n == 0) chk("dmem_timeout_we", 32'(bus.dmem_we), 32'd1);
         n++;
      end
      chk("dmem_timeout_len", 32'(n), 32'd4);
      chk("dmem_timeout_err", 32'(bus.err), 32'd1);
      step(0, ST, 0, 0);
      chk("reset_clears_err", 32'(bus.err), 32'd0);
      step(1, ST, 0, 0);
      chk("after_reset_idle", 32'(obs), 32'(O_IDLE));
      step(1, ST, 0, 0);
      chk("after_reset_fetch", 32'(obs), 32'(O_FW));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
